multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style sequencer for the multicycle version of the CPU datapath: IR, PC, register file, ALU and a single shared instruction/data memory port.
- Decodes the 6-bit opcode held in IR and steps the datapath through FETCH/DECODE/EXECUTE/MEM/WB.
- Drives all datapath enables and mux selects, handshakes with memory, and keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active low
- opcode  in  6  IR[31:26], only used in DECODE
- zero  in  1  ALU zero flag, only used in BRANCH
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- iord  out  1  address mux: 0=PC, 1=ALUOut
- ir_write  out  1  IR load enable
- pc_en  out  1  PC load enable
- pc_source  out  2  PC mux: 00=ALU, 01=ALUOut, 10=jump target
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct decode
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- reg_write  out  1  register file write enable
- state  out  4  current state encoding
- illegal_op  out  1  sticky illegal-opcode flag
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: rst_n low at a rising edge forces state=S_RST (0), illegal_op=0, retired=0. This applies from any state, including mid-memory access.
- S_RST: all outputs 0. The first clock edge after reset is released moves to FETCH.
- State encoding: S_RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10. Codes 11-15 are unreachable; if entered, go to S_RST.
- Outputs not listed for a state are 0.
- FETCH:
  - mem_req=1, mem_read=1, iord=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_en=mem_ready (only these two are combinational on an input).
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_b=11, alu_op=00 (precompute branch target).
  - Next state by opcode:
    - 000000 -> EXEC
    - 100011 and 100000 -> MEMADR (load)
    - 101011 -> MEMADR (store)
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - any other -> FETCH, set illegal_op=1, not counted as retired.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Load opcodes go to MEMRD; 101011 goes to MEMWR. The opcode is re-read here; IR is stable because ir_write=0.
- MEMRD: mem_req=1, mem_read=1, iord=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Stay until mem_ready=1, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero. Go to FETCH.
- JUMP: pc_source=10, pc_en=1. Go to FETCH.
- Retire rules:
  - retired increments by 1 on transitions to FETCH from MEMWB, MEMWR (with mem_ready), RWB, BRANCH and JUMP.
  - It saturates at all-ones and does not wrap.
- illegal_op is cleared only by reset.
- Cycle counts with mem_ready always 1:
  - R-type: 4 (FETCH, DECODE, EXEC, RWB)
  - load: 5
  - store: 4
  - beq: 3
  - j: 3
- Each memory wait cycle adds 1.
- mem_req is never dropped while waiting. mem_read and mem_write are never both 1.

Test Plan:
- Reset, then opcode=000000 with mem_ready=1 -> state sequence 0,1,2,7,8,1; reg_write=1 and reg_dst=1 only in state 8; retired=1.
- opcode=100011, mem_ready low for 2 cycles in MEMRD -> states 1,2,3,4,4,4,5,1; mem_req stays high for 3 cycles in state 4; mem_to_reg=1 in state 5; retired increments once.
- opcode=101011 with mem_ready=1 -> states 1,2,3,6,1; mem_write=1 and iord=1 for exactly 1 cycle; reg_write is never 1.
- opcode=000100: run once with zero=1 and once with zero=0 -> in state 9, pc_en=1 / pc_en=0 respectively; pc_source=01 and alu_op=01 in both runs; retired increments in both.
- opcode=111111 -> states 1,2,1; illegal_op=1 from the next cycle and stays 1 through later instructions; retired unchanged.
- rst_n=0 during MEMRD while mem_ready=0 -> next state 0; all outputs 0; illegal_op=0; retired=0; FETCH resumes one cycle after rst_n returns to 1.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle CPU datapath: walks FETCH/DECODE/EXECUTE/MEM/WB,
// drives datapath enables and mux selects, counts retired instructions, flags illegal opcodes.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e            state_q, state_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC+4 commit in the same cycle the instruction word arrives
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_LB,
                    OP_SW:        state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_en     = zero;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            default: state_d = S_RST;
        endcase

        retired_d = retired_q;
        if (retire && (retired_q != {CNT_W{1'b1}})) retired_d = retired_q + CNT_W'(1);
    end

    assign state      = state_q;
    assign illegal_op = illegal_q;
    assign retired    = retired_q;

endmodule
